// File: rtl/alu_nibble_seq_if.sv
// Bundle for alu_nibble_seq: control-unit handshake, operands/results, and the
// combinational drive/capture pins of the external 4-bit 74181-style slice.
interface alu_nibble_seq_if #(
  parameter int NIBBLES = 4
);
  localparam int W = 4 * NIBBLES;

  logic         start;
  logic         busy;
  logic [3:0]   op_s;
  logic         op_m;
  logic         cin_n;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic [W-1:0] result;
  logic         cout_n;
  logic         zero;
  logic         aeqb;
  logic         done;

  logic [3:0]   alu_a;
  logic [3:0]   alu_b;
  logic [3:0]   alu_s;
  logic         alu_m;
  logic         alu_c0;
  logic [3:0]   alu_f;
  logic         alu_c4;
  logic         alu_aeqb;

  // master: control unit plus the ALU slice; slave: the sequencer itself
  modport master (
    output start, op_s, op_m, cin_n, a_in, b_in,
    input  busy, result, cout_n, zero, aeqb, done,
    input  alu_a, alu_b, alu_s, alu_m, alu_c0,
    output alu_f, alu_c4, alu_aeqb
  );

  modport slave (
    input  start, op_s, op_m, cin_n, a_in, b_in,
    output busy, result, cout_n, zero, aeqb, done,
    output alu_a, alu_b, alu_s, alu_m, alu_c0,
    input  alu_f, alu_c4, alu_aeqb
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// Drives one external 4-bit ALU slice LSB nibble first, chaining active-low carry.
// Optional macro ALU_SEQ_AEQB_EN builds the all-nibbles A=B accumulator.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  alu_nibble_seq_if.slave  bus
);
  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state_reg;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [3:0]    s_reg;
  logic          m_reg;
  logic          carry_reg;
  logic [IW-1:0] idx_reg;
  logic [W-1:0]  shadow_reg;
  logic [W-1:0]  result_reg;
  logic          cout_reg;
  logic          zero_reg;
  logic          aeqb_reg;
  logic          done_reg;
  logic          busy_reg;

  logic [3:0] a_nib [NIBBLES];
  logic [3:0] b_nib [NIBBLES];

  genvar gi;
  generate
    for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
      assign a_nib[gi] = a_reg[4*gi +: 4];
      assign b_nib[gi] = b_reg[4*gi +: 4];
    end
  endgenerate

`ifdef ALU_SEQ_AEQB_EN
  logic acc_reg;
`else
  logic unused_alu_aeqb;
  assign unused_alu_aeqb = bus.alu_aeqb;
`endif

  // Slice pins are only meaningful in RUN; elsewhere they sit at their reset values.
  always_comb begin
    bus.alu_a  = 4'h0;
    bus.alu_b  = 4'h0;
    bus.alu_s  = 4'h0;
    bus.alu_m  = 1'b0;
    bus.alu_c0 = 1'b1;
    if (state_reg == RUN) begin
      bus.alu_a  = a_nib[idx_reg];
      bus.alu_b  = b_nib[idx_reg];
      bus.alu_s  = s_reg;
      bus.alu_m  = m_reg;
      bus.alu_c0 = carry_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      a_reg      <= '0;
      b_reg      <= '0;
      s_reg      <= 4'h0;
      m_reg      <= 1'b0;
      carry_reg  <= 1'b1;
      idx_reg    <= '0;
      shadow_reg <= '0;
      result_reg <= '0;
      cout_reg   <= 1'b1;
      zero_reg   <= 1'b1;
      aeqb_reg   <= 1'b0;
      done_reg   <= 1'b0;
      busy_reg   <= 1'b0;
`ifdef ALU_SEQ_AEQB_EN
      acc_reg    <= 1'b0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= bus.a_in;
            b_reg     <= bus.b_in;
            s_reg     <= bus.op_s;
            m_reg     <= bus.op_m;
            carry_reg <= bus.cin_n;
            idx_reg   <= '0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
`ifdef ALU_SEQ_AEQB_EN
            acc_reg   <= 1'b1;
`endif
          end
        end
        RUN: begin
          shadow_reg[4*idx_reg +: 4] <= bus.alu_f;
          carry_reg <= bus.alu_c4;
`ifdef ALU_SEQ_AEQB_EN
          acc_reg   <= acc_reg & bus.alu_aeqb;
`endif
          if (idx_reg == LAST) begin
            idx_reg   <= '0;
            state_reg <= DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        DONE: begin
          // Visible outputs change only here, so they never show a partial result.
          result_reg <= shadow_reg;
          cout_reg   <= m_reg ? 1'b1 : carry_reg;
          zero_reg   <= (shadow_reg == '0);
`ifdef ALU_SEQ_AEQB_EN
          aeqb_reg   <= acc_reg;
`else
          aeqb_reg   <= 1'b0;
`endif
          done_reg   <= 1'b1;
          busy_reg   <= 1'b0;
          state_reg  <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.result = result_reg;
  assign bus.cout_n = cout_reg;
  assign bus.zero   = zero_reg;
  assign bus.aeqb   = aeqb_reg;
  assign bus.done   = done_reg;
  assign bus.busy   = busy_reg;
endmodule

// File: tb/tb_alu_nibble_seq.sv
// Randomized scoreboard bench for alu_nibble_seq with a behavioural 74181 slice
// and a full-width function-table reference model.
module tb_alu_nibble_seq;
  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;
`ifdef ALU_SEQ_AEQB_EN
  localparam bit AEQB_EN = 1'b1;
`else
  localparam bit AEQB_EN = 1'b0;
`endif

  typedef struct packed {
    logic [W-1:0] r;
    logic         c;
    logic         z;
    logic         e;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int vectors = 0;
  int miscompares = 0;
  exp_t sb_q[$];
  exp_t mon_exp;
  exp_t mon_got;

  alu_nibble_seq_if #(.NIBBLES(NIBBLES)) bus ();

  alu_nibble_seq #(.NIBBLES(NIBBLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // 74181 slice, active-high data, active-low carries
  logic [3:0] sl_x, sl_y;
  logic [4:0] sl_sum;
  always_comb begin
    sl_x = bus.alu_a | (bus.alu_s[0] ? bus.alu_b : 4'h0) | (bus.alu_s[1] ? ~bus.alu_b : 4'h0);
    sl_y = (bus.alu_s[2] ? (bus.alu_a & ~bus.alu_b) : 4'h0) | (bus.alu_s[3] ? (bus.alu_a & bus.alu_b) : 4'h0);
    sl_sum = {1'b0, sl_x} + {1'b0, sl_y} + {4'h0, ~bus.alu_c0};
    bus.alu_f    = bus.alu_m ? ~(sl_x ^ sl_y) : sl_sum[3:0];
    bus.alu_c4   = ~sl_sum[4];
    bus.alu_aeqb = &bus.alu_f;
  end

  // Full-width reference from the datasheet function table
  function automatic exp_t model(input logic [3:0] s, input logic m, input logic cin_n,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t o;
    logic [W-1:0] nb, ones, x, y, f;
    logic [W:0] sum;
    nb = ~b;
    ones = '1;
    x = a;
    y = '0;
    f = '0;
    if (m) begin
      case (s)
        4'h0: f = ~a;        4'h1: f = ~(a | b);   4'h2: f = ~a & b;   4'h3: f = '0;
        4'h4: f = ~(a & b);  4'h5: f = nb;         4'h6: f = a ^ b;    4'h7: f = a & nb;
        4'h8: f = ~a | b;    4'h9: f = ~(a ^ b);   4'hA: f = b;        4'hB: f = a & b;
        4'hC: f = ones;      4'hD: f = a | nb;     4'hE: f = a | b;    default: f = a;
      endcase
      o.c = 1'b1;
    end else begin
      case (s)
        4'h0: begin x = a;      y = '0;     end
        4'h1: begin x = a | b;  y = '0;     end
        4'h2: begin x = a | nb; y = '0;     end
        4'h3: begin x = ones;   y = '0;     end
        4'h4: begin x = a;      y = a & nb; end
        4'h5: begin x = a | b;  y = a & nb; end
        4'h6: begin x = a;      y = nb;     end
        4'h7: begin x = a & nb; y = ones;   end
        4'h8: begin x = a;      y = a & b;  end
        4'h9: begin x = a;      y = b;      end
        4'hA: begin x = a | nb; y = a & b;  end
        4'hB: begin x = a & b;  y = ones;   end
        4'hC: begin x = a;      y = a;      end
        4'hD: begin x = a | b;  y = a;      end
        4'hE: begin x = a | nb; y = a;      end
        default: begin x = a;   y = ones;   end
      endcase
      sum = {1'b0, x} + {1'b0, y} + ((W+1)'(cin_n ? 0 : 1));
      f = sum[W-1:0];
      o.c = ~sum[W];
    end
    o.r = f;
    o.z = (f == '0);
    o.e = AEQB_EN && (f == ones);
    return o;
  endfunction

  // Monitor: pops one expectation per done pulse
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      vectors++;
      mon_got = '{r: bus.result, c: bus.cout_n, z: bus.zero, e: bus.aeqb};
      if (sb_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_done result=%h cout_n=%b", bus.result, bus.cout_n);
      end else begin
        mon_exp = sb_q.pop_front();
        if (mon_got !== mon_exp)
        begin
          miscompares++;
          $display("FAIL scoreboard got r=%h c=%b z=%b e=%b want r=%h c=%b z=%b e=%b",
                   mon_got.r, mon_got.c, mon_got.z, mon_got.e,
                   mon_exp.r, mon_exp.c, mon_exp.z, mon_exp.e);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Waits for done after the start-sampling edge; records RUN-cycle carry-ins.
  task automatic wait_done(output int lat, output logic [3:0] c0s);
    lat = 0;
    c0s = 4'h0;
    c0s[0] = bus.alu_c0;
    for (int k = 1; k <= 20; k++) begin
      if (lat == 0) begin
        @(posedge clk); #1;
        if (k < 4) c0s[k] = bus.alu_c0;
        if (bus.done) lat = k;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout busy=%b", bus.busy);
    end else begin
      chk("latency", 32'(lat), 32'(NIBBLES + 1));
    end
  endtask

  task automatic issue(input logic [3:0] s, input logic m, input logic c,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    bus.op_s = s; bus.op_m = m; bus.cin_n = c; bus.a_in = a; bus.b_in = b;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] s, input logic m, input logic c,
                        input logic [W-1:0] a, input logic [W-1:0] b, output logic [3:0] c0s);
    int lat;
    issue(s, m, c, a, b);
    sb_q.push_back(model(s, m, c, a, b));
    wait_done(lat, c0s);
  endtask

  logic [3:0] c0s;
  int lat;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0; bus.op_s = 4'h0; bus.op_m = 1'b0; bus.cin_n = 1'b1;
    bus.a_in = '0; bus.b_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_flags", {bus.cout_n, bus.zero, bus.aeqb, bus.done, bus.busy}, 32'b11000);
    chk("rst_slice", {bus.alu_a, bus.alu_b, bus.alu_s, bus.alu_m, bus.alu_c0}, 32'h1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(4'b1001, 1'b0, 1'b1, 16'h1234, 16'h0FFF, c0s);
    chk("add_result", 32'(bus.result), 32'h2233);
    chk("add_flags", {bus.cout_n, bus.zero}, 32'b10);

    run_op(4'b1001, 1'b0, 1'b1, 16'hFFFF, 16'h0001, c0s);
    chk("carry_result", 32'(bus.result), 32'h0);
    chk("carry_flags", {bus.cout_n, bus.zero}, 32'b01);
    chk("carry_c0_seq", 32'(c0s), 32'b0001);

    run_op(4'b0110, 1'b0, 1'b0, 16'h0005, 16'h0003, c0s);
    chk("sub_result", 32'(bus.result), 32'h2);
    chk("sub_cout", 32'(bus.cout_n), 32'h0);
    run_op(4'b0110, 1'b0, 1'b0, 16'h0003, 16'h0005, c0s);
    chk("sub_borrow_result", 32'(bus.result), 32'hFFFE);
    chk("sub_borrow_cout", 32'(bus.cout_n), 32'h1);

    run_op(4'b0110, 1'b1, 1'b0, 16'hF0F0, 16'hFF00, c0s);
    chk("xor_result", 32'(bus.result), 32'h0FF0);
    chk("xor_cout", 32'(bus.cout_n), 32'h1);
    run_op(4'b1100, 1'b1, 1'b1, 16'h1357, 16'h2468, c0s);
    chk("ones_result", 32'(bus.result), 32'hFFFF);
    chk("ones_aeqb", 32'(bus.aeqb), 32'(AEQB_EN));

    // start while busy must be ignored
    issue(4'b1001, 1'b0, 1'b1, 16'h0100, 16'h0023);
    sb_q.push_back(model(4'b1001, 1'b0, 1'b1, 16'h0100, 16'h0023));
    @(posedge clk); #1;
    chk("busy_run", 32'(bus.busy), 32'h1);
    bus.op_s = 4'b0011; bus.a_in = 16'hAAAA; bus.b_in = 16'h5555; bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int k = 0; k < 12 && !bus.done; k++) begin
      @(posedge clk); #1;
    end
    chk("busy_ignore_done", 32'(bus.done), 32'h1);
    chk("busy_ignore_result", 32'(bus.result), 32'h0123);
    repeat (8) @(posedge clk);
    #1;

    // abort in the 2nd RUN cycle
    issue(4'b1001, 1'b0, 1'b1, 16'h4444, 16'h1111);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    chk("abort_result", 32'(bus.result), 32'h0);
    chk("abort_done", 32'(bus.done), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    run_op(4'b1001, 1'b0, 1'b1, 16'h4444, 16'h1111, c0s);
    chk("post_abort_result", 32'(bus.result), 32'h5555);

    for (int n = 0; n < 40; n++) begin
      run_op(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             16'($urandom), 16'($urandom), c0s);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/alu_nibble_seq.md
Name: alu_nibble_seq

Overview:
- Multi-cycle controller that performs one NIBBLES×4-bit ALU operation by driving a single external 4-bit 74181-style ALU slice one nibble per cycle.
- Works LSB nibble first and chains the slice's carry-out into the next nibble's carry-in.
- Sits between the model machine's control unit (start/done handshake) and the 4-bit ALU slice (combinational drive/capture).

Parameters:
- NIBBLES, 4: number of nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- start  input  1  operation request; sampled only in IDLE.
- busy  output  1  high from the cycle after start is accepted until done.
- op_s  input  4  function select S, latched on start.
- op_m  input  1  mode M (1 = logic, 0 = arithmetic), latched on start.
- cin_n  input  1  active-low carry-in for nibble 0, latched on start.
- a_in  input  W  operand A, latched on start.
- b_in  input  W  operand B, latched on start.
- result  output  W  assembled F; updated only at completion.
- cout_n  output  1  active-low carry-out of the top nibble; forced 1 when M=1.
- zero  output  1  result == 0.
- aeqb  output  1  all-ones compare flag (see Optional Feature).
- done  output  1  one-cycle completion pulse.
- alu_a  output  4  A nibble to the slice.
- alu_b  output  4  B nibble to the slice.
- alu_s  output  4  S to the slice.
- alu_m  output  1  M to the slice.
- alu_c0  output  1  active-low carry-in to the slice.
- alu_f  input  4  slice F.
- alu_c4  input  1  slice active-low carry-out.
- alu_aeqb  input  1  slice A=B output (F all ones).

Behaviour:
- Reset (async, any state): state=IDLE; result=0; cout_n=1; zero=1; aeqb=0; done=0; busy=0; nibble index=0; alu_* outputs=0 except alu_c0=1.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a_in, b_in, op_s, op_m, cin_n; carry register ← cin_n; index ← 0; next state RUN.
  - start=0 stays in IDLE.
- RUN:
  - Combinationally drive alu_a=A[4i+3:4i], alu_b=B[4i+3:4i], alu_s, alu_m from latched values, and alu_c0=carry register.
  - Each clock edge: result-shadow nibble i ← alu_f; carry register ← alu_c4; index ← i+1.
  - When i = NIBBLES-1, the edge moves to DONE.
- DONE (exactly one cycle):
  - result ← shadow; cout_n ← (op_m ? 1 : carry register); zero and aeqb updated; done=1.
  - Next state IDLE.
- Latency: start sampled at edge t → done high in cycle t+NIBBLES+1; next start accepted in that same DONE cycle's following edge only, i.e. from the IDLE cycle onward.
- busy=1 in RUN and DONE; start while busy is ignored, latched operands are unchanged.
- result, cout_n, zero and aeqb hold until the next completion; they never show partial values.
- M=1: the carry chain still propagates alu_c4 but does not affect the slice; cout_n is reported as 1.
- Carry convention:
  - Both alu_c0 and alu_c4 are active-low and chained without inversion.
  - For subtract (S=0110, M=0), cin_n=0 means A−B and cout_n=1 means a borrow occurred.
- Reset mid-RUN aborts the operation; no done pulse is issued.

Optional Feature:
- Macro: ALU_SEQ_AEQB_EN.
- Defined: an aeqb accumulator is set to 1 on start and ANDed with alu_aeqb each RUN cycle; the accumulated value is registered to aeqb at completion (1 iff every nibble F = 1111).
- Undefined: no accumulator is built; aeqb is tied to 0.

Test Plan:
- Add, NIBBLES=4: S=1001, M=0, cin_n=1, A=0x1234, B=0x0FFF → done 5 cycles after start; result=0x2233, cout_n=1, zero=0.
- Carry out: S=1001, M=0, cin_n=1, A=0xFFFF, B=0x0001 → result=0x0000, cout_n=0, zero=1; alu_c0 observed 1,0,0,0 across the 4 RUN cycles.
- Subtract: S=0110, M=0, cin_n=0, A=0x0005, B=0x0003 → 0x0002, cout_n=0; then A=0x0003, B=0x0005 → 0xFFFE, cout_n=1.
- Logic XOR: S=0110, M=1, A=0xF0F0, B=0xFF00 → result=0x0FF0, cout_n=1; with ALU_SEQ_AEQB_EN, S=1100, M=1 → 0xFFFF, aeqb=1.
- Busy and abort:
  - start pulsed during RUN with different operands → ignored, first result unchanged.
  - rst asserted in the 2nd RUN cycle → busy=0, result=0, no done pulse; a fresh start afterwards completes normally.
